fb_scanout: RTL
===============

# fb_scanout

Video-side consumer of the dual-port framebuffer: tracks the incoming display timing, issues framebuffer read addresses, and drives registered RGB888 plus delayed sync/DE to the video encoder. It upscales the 240x180 RGB565 image by an integer factor and centres it in the active area, filling the surround with a border colour. It replaces direct address generation in the top level and sits between the video timing generator and the TMDS/LCD output stage.

## Interface
- IMG_W, 240, framebuffer image width in pixels
- IMG_H, 180, framebuffer image height in lines
- SCALE, 3, integer upscale factor, 1..8, applied identically in both axes
- X_OFF, 280, first active-pixel column of the image window
- Y_OFF, 90, first active line of the image window
- BORDER, 24'h000000, RGB888 colour driven outside the window
- clk  in  1  pixel clock; the framebuffer read port runs on the same clock
- rst_n  in  1  asynchronous active-low reset
- vid_de  in  1  active-video strobe from the timing generator
- vid_hs  in  1  hsync, passed through with its polarity unchanged
- vid_vs  in  1  vsync, active-high; rising edge marks start of frame
- test_en  in  1  selects the test pattern (present only with SCANOUT_TESTPAT_EN)
- rd_addr  out  16  framebuffer read address
- rd_data  in  16  framebuffer RGB565 data, valid one clk after rd_addr
- out_rgb  out  24  RGB888 pixel
- out_de  out  1  delayed vid_de
- out_hs  out  1  delayed vid_hs
- out_vs  out  1  delayed vid_vs

## Operation
- Counters:
  - hx counts vid_de cycles within a line and clears when vid_de is low.
  - vy counts active lines. It increments on each vid_de falling edge and clears on the vid_vs rising edge.
- Window:
  - in_win = vid_de && hx in [X_OFF, X_OFF+IMG_W*SCALE) && vy in [Y_OFF, Y_OFF+IMG_H*SCALE).
- Address generation uses no multiplier:
  - col advances by 1 every SCALE in-window pixels, using a sub-counter sx in 0..SCALE-1.
  - row_base advances by IMG_W every SCALE window lines, using a sub-counter sy.
  - rd_addr = row_base + col, 16-bit unsigned. The maximum value IMG_W*IMG_H-1 must not wrap.
  - col and sx reset at every line start. row_base and sy reset at vid_vs rising edge.
- Sync state: the block is in UNSYNCED after reset and moves to SYNCED on the first vid_vs rising edge. While UNSYNCED, out_rgb = BORDER and syncs pass through.
- Pixel conversion:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- Outside in_win, out_rgb = BORDER. rd_addr holds its last value.
- vid_vs rising edge mid-line: clears vy, row_base, sy, col and sx immediately. The current line finishes as border.
- A line or frame shorter than the window is truncated with no error. Counters do not wrap and saturate at their maximum.

## Timing
- Pipeline, in clk cycles:
  - S0: counters evaluate.
  - S1: rd_addr registered.
  - S2: rd_data returned by the BSRAM.
  - S3: out_rgb registered.
- Total latency is 3 cycles from vid_* to out_*. vid_de, vid_hs, vid_vs and in_win are delayed by exactly 3 registers, so they stay aligned with pixel data.
- The first in-window pixel of a line appears on out_rgb exactly 3 cycles after the vid_de sample with hx = X_OFF.
- All outputs reset asynchronously to 0 (rd_addr, out_rgb, out_de, out_hs, out_vs). The state returns to UNSYNCED.
- Reset deasserted mid-frame: output stays BORDER until the next vid_vs rising edge, because the block remains UNSYNCED.

## Configuration
- SCANOUT_TESTPAT_EN defined:
  - Port test_en exists.
  - When test_en = 1, the in-window pixel is replaced by 8 vertical colour bars, each IMG_W*SCALE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - The test pattern has the same latency as framebuffer data. rd_addr continues to advance as normal.
- SCANOUT_TESTPAT_EN undefined: the port and the pattern logic are absent, and behaviour is identical to test_en = 0.

## Test plan
- 1280x720 timing with SCALE=3 and a framebuffer model where mem[a] = a -> the first window pixel is at line 90, col 280, with rd_addr=0. Line 93 starts at rd_addr=240. The last window pixel has rd_addr=43199. out_rgb matches the RGB565->888 expansion.
- rd_data=16'hF800 in window -> out_rgb=24'hFF0000. rd_data=16'h07E0 -> 24'h00FF00. Outside the window -> BORDER.
- Reset pulsed mid-frame, then released -> all outputs 0 during reset. out_rgb=BORDER until the next vid_vs rising edge. The following frame starts at rd_addr=0.
- vid_vs rising edge injected mid-line at hx=500 -> the remainder of the line is border. The next line is treated as vy=0 and row_base=0.
- Alignment check: out_de, out_hs and out_vs equal vid_de, vid_hs and vid_vs delayed by exactly 3 cycles throughout a full frame.
- With SCANOUT_TESTPAT_EN and test_en=1 -> window pixel hx=X_OFF gives 24'hFFFFFF. Pixel hx=X_OFF+90 gives yellow, 24'hFFFF00.

Source files
------------

// File: rtl/fb_scanout.sv
// Framebuffer scanout: upscales and centres the framebuffer image in the active area, with a 3-cycle aligned pipeline.
// Optional build macro SCANOUT_TESTPAT_EN adds the test_en port and a vertical colour-bar pattern.
//
// state    | meaning
// UNSYNCED | no vid_vs rising edge seen since reset; the output shows only the border colour
// SYNCED   | frame position known; the image window is scanned out
module fb_scanout #(
  parameter int          IMG_W  = 240,
  parameter int          IMG_H  = 180,
  parameter int          SCALE  = 3,
  parameter int          X_OFF  = 280,
  parameter int          Y_OFF  = 90,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
`ifdef SCANOUT_TESTPAT_EN
  input  logic        test_en,
`endif
  output logic [15:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic [23:0] out_rgb,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs
);

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] X_LO = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0] X_HI = CNT_W'(X_OFF + IMG_W * SCALE);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y_OFF);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y_OFF + IMG_H * SCALE);
  localparam logic [2:0]  SC_LAST = 3'(SCALE - 1);
  localparam logic [15:0] ROW_STEP = 16'(IMG_W);

  typedef enum logic {UNSYNCED = 1'b0, SYNCED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             vs_prev, de_prev;
  logic             vs_rise, de_fall;
  logic [CNT_W-1:0] hx, vy;
  logic             line_kill;
  logic             x_in, y_in, in_win;
  logic [2:0]       sx, sy;
  logic [15:0]      col, row_base;
  logic [2:0]       de_pipe, hs_pipe, vs_pipe;
  logic [1:0]       win_pipe;
  logic [23:0]      pix_rgb;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign vs_rise = vid_vs & ~vs_prev;
  assign de_fall = de_prev & ~vid_de;
  assign x_in    = (hx >= X_LO) && (hx < X_HI);
  assign y_in    = (vy >= Y_LO) && (vy < Y_HI);
  // A vsync edge inside a line blanks the rest of that line immediately.
  assign in_win  = vid_de && (state == SYNCED) && !line_kill && !vs_rise && x_in && y_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNSYNCED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNSYNCED: if (vs_rise) state_nxt = SYNCED;
      SYNCED:   state_nxt = SYNCED;
      default:  state_nxt = UNSYNCED;
    endcase
  end

  // vs_prev resets high so a vsync already high at reset release is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b1;
      de_prev   <= 1'b0;
      hx        <= '0;
      vy        <= '0;
      line_kill <= 1'b0;
    end else begin
      vs_prev <= vid_vs;
      de_prev <= vid_de;
      if (!vid_de)          hx <= '0;
      else if (hx != CNT_MAX) hx <= hx + 1'b1;
      if (vs_rise)                                 vy <= '0;
      else if (de_fall && !line_kill && vy != CNT_MAX) vy <= vy + 1'b1;
      if (!vid_de)      line_kill <= 1'b0;
      else if (vs_rise) line_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy       <= '0;
      row_base <= '0;
    end else if (vs_rise) begin
      sy       <= '0;
      row_base <= '0;
    end else if (de_fall && !line_kill && y_in) begin
      if (sy == SC_LAST) begin
        sy       <= '0;
        row_base <= row_base + ROW_STEP;
      end else begin
        sy <= sy + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx  <= '0;
      col <= '0;
    end else if (!vid_de || vs_rise) begin
      sx  <= '0;
      col <= '0;
    end else if (in_win) begin
      if (sx == SC_LAST) begin
        sx  <= '0;
        col <= col + 16'd1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_addr <= '0;
    else if (in_win) rd_addr <= row_base + col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe  <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      win_pipe <= '0;
    end else begin
      de_pipe  <= {de_pipe[1:0], vid_de};
      hs_pipe  <= {hs_pipe[1:0], vid_hs};
      vs_pipe  <= {vs_pipe[1:0], vid_vs};
      win_pipe <= {win_pipe[0], in_win};
    end
  end

  assign out_de = de_pipe[2];
  assign out_hs = hs_pipe[2];
  assign out_vs = vs_pipe[2];

`ifdef SCANOUT_TESTPAT_EN
  localparam logic [15:0] BAR_LAST = 16'(IMG_W * SCALE / 8 - 1);

  logic [15:0] bx;
  logic [2:0]  bar_idx, bar_d1, bar_d2;
  logic        tp_d1, tp_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx      <= '0;
      bar_idx <= '0;
    end else if (!vid_de || vs_rise) begin
      bx      <= '0;
      bar_idx <= '0;
    end else if (in_win) begin
      if (bx == BAR_LAST) begin
        bx <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
      end else begin
        bx <= bx + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_d1 <= '0;
      bar_d2 <= '0;
      tp_d1  <= 1'b0;
      tp_d2  <= 1'b0;
    end else begin
      bar_d1 <= bar_idx;
      bar_d2 <= bar_d1;
      tp_d1  <= test_en;
      tp_d2  <= tp_d1;
    end
  end

  // Bar order white..black maps onto inverted index bits: R=~i[1], G=~i[2], B=~i[0].
  always_comb begin
    pix_rgb = rgb565_to_888(rd_data);
    if (tp_d2) pix_rgb = {{8{~bar_d2[1]}}, {8{~bar_d2[2]}}, {8{~bar_d2[0]}}};
  end
`else
  always_comb begin
    pix_rgb = rgb565_to_888(rd_data);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_rgb <= '0;
    else        out_rgb <= win_pipe[1] ? pix_rgb : BORDER;
  end

endmodule
